mysystem_pio_out: RTL and testbench

Avalon-MM slave output PIO, the write-side counterpart of the system's input PIO. It drives a registered out_port from CPU writes. Supported writes: full data register writes, atomic bit set and bit clear, and self-timed auto-clearing pulses of a programmable cycle length. It sits on the system interconnect as a 3-bit-address, 32-bit-data slave with zero wait states.

---
 rtl/mysystem_pio_out_if.sv | 25 ++
 rtl/mysystem_pio_out.sv | 143 ++++++++++++++
 tb/tb_mysystem_pio_out.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mysystem_pio_out_if.sv
// Avalon-MM slave bus bundle for the output PIO: 3-bit word address, 32-bit data,
// zero wait states, registered read data.
interface mysystem_pio_out_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/mysystem_pio_out.sv
// Output PIO: registered out_port driven by CPU writes, with atomic set/clear and a
// self-timed pulse engine that drops pulsed bits after PULSE_LEN cycles.
module mysystem_pio_out #(
    parameter int          DATA_WIDTH    = 16,
    parameter logic [31:0] RESET_VALUE   = 32'd0,
    parameter int          PULSE_DEFAULT = 1000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    mysystem_pio_out_if.slave     bus,
    output logic [DATA_WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_LEN    = 3'd1;
    localparam logic [2:0] ADDR_SET    = 3'd4;
    localparam logic [2:0] ADDR_CLR    = 3'd5;
    localparam logic [2:0] ADDR_PULSE  = 3'd6;
    localparam logic [2:0] ADDR_STATUS = 3'd7;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [15:0]           len_q, len_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [31:0]           rdata_q, rdata_d;

    logic [DATA_WIDTH-1:0] wd;
    logic                  wr;
    logic                  wr_data, wr_len, wr_set, wr_clr, wr_pulse;
    logic                  expire;
    logic                  busy;
    logic [15:0]           mask_ext;
    logic [31:0]           out_ext;
    logic                  unused_wd;

    assign wd        = bus.writedata[DATA_WIDTH-1:0];
    assign unused_wd = ^bus.writedata;
    assign wr        = bus.chipselect & ~bus.write_n;
    assign wr_data   = wr && (bus.address == ADDR_DATA);
    assign wr_len    = wr && (bus.address == ADDR_LEN);
    assign wr_set    = wr && (bus.address == ADDR_SET);
    assign wr_clr    = wr && (bus.address == ADDR_CLR);
    // A zero pulse length makes the whole PULSE write a no-op.
    assign wr_pulse  = wr && (bus.address == ADDR_PULSE) && (len_q != 16'd0);
    assign expire    = (state_q == ACTIVE) && (cnt_q == 16'd1);

    // Pulse FSM state register, carrying the countdown with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: expiry/decrement first, then the bus write overrides.
    always_comb begin
        cnt_d = 16'd0;
        if (state_q == ACTIVE && !expire) begin
            cnt_d = cnt_q - 16'd1;
        end
        if (wr_data) begin
            cnt_d = 16'd0;
        end
        if (wr_pulse) begin
            cnt_d = len_q;
        end
        state_d = (cnt_d != 16'd0) ? ACTIVE : IDLE;
    end

    // Per-bit output and mask update: expiry drops masked bits, then writes land on top.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
            logic out_exp;
            logic hit;
            assign hit         = wd[gi];
            assign out_exp     = out_q[gi] & ~(expire & mask_q[gi]);
            assign out_d[gi]   = (wr_pulse & hit) ? 1'b1 :
                                 (wr_set   & hit) ? 1'b1 :
                                 (wr_clr   & hit) ? 1'b0 :
                                 wr_data          ? hit  : out_exp;
            assign mask_d[gi]  = (wr_pulse & hit) ? 1'b1 :
                                 (wr_data | ((wr_set | wr_clr) & hit)) ? 1'b0 :
                                 (mask_q[gi] & ~expire);
        end
    endgenerate

    always_comb begin
        len_d = len_q;
        if (wr_len) begin
            len_d = bus.writedata[15:0];
        end
    end

    // Mask is only visible in STATUS when it fits in the low half-word.
    generate
        if (DATA_WIDTH <= 16) begin : g_mask_vis
            assign mask_ext = 16'(mask_q);
        end else begin : g_mask_hid
            assign mask_ext = 16'd0;
        end
    endgenerate

    // FSM outputs and the read mux; readdata follows address every cycle.
    always_comb begin
        busy    = (state_q == ACTIVE);
        out_ext = 32'(out_q);
        rdata_d = 32'd0;
        case (bus.address)
            ADDR_DATA:   rdata_d = out_ext;
            ADDR_LEN:    rdata_d = {16'd0, len_q};
            ADDR_STATUS: rdata_d = {16'd0, mask_ext[15:1], busy};
            default:     rdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q   <= RESET_VALUE[DATA_WIDTH-1:0];
            mask_q  <= '0;
            len_q   <= 16'(PULSE_DEFAULT);
            rdata_q <= 32'd0;
        end else begin
            out_q   <= out_d;
            mask_q  <= mask_d;
            len_q   <= len_d;
            rdata_q <= rdata_d;
        end
    end

    assign out_port     = out_q;
    assign bus.readdata = rdata_q;

endmodule

// File: tb/tb_mysystem_pio_out.sv
// Bench for mysystem_pio_out: behavioural register model feeding a scoreboard queue,
// plus directed checks on the documented pulse timing and reset cases.
module tb_mysystem_pio_out;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] out_port;

    mysystem_pio_out_if bus ();

    mysystem_pio_out #(
        .DATA_WIDTH    (16),
        .RESET_VALUE   (32'd0),
        .PULSE_DEFAULT (1000)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] out;
        logic [31:0] rd;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    logic [15:0] m_out, m_mask, m_len;
    int          m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_out  = 16'h0000;
        m_mask = 16'h0000;
        m_len  = 16'd1000;
        m_cnt  = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return {16'd0, m_out};
            3'd1:    return {16'd0, m_len};
            3'd7:    return {16'd0, m_mask[15:1], (m_cnt != 0)};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_update(input logic w, input logic [2:0] a, input logic [31:0] d);
        logic [15:0] v;
        v = d[15:0];
        if (m_cnt == 1) begin
            m_out  = m_out & ~m_mask;
            m_mask = 16'h0000;
            m_cnt  = 0;
        end else if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
        end
        if (w) begin
            case (a)
                3'd0: begin m_out = v; m_mask = 16'h0000; m_cnt = 0; end
                3'd1: m_len = v;
                3'd4: begin m_out = m_out | v; m_mask = m_mask & ~v; end
                3'd5: begin m_out = m_out & ~v; m_mask = m_mask & ~v; end
                3'd6: if (m_len != 16'd0) begin
                          m_out  = m_out | v;
                          m_mask = m_mask | v;
                          m_cnt  = int'(m_len);
                      end
                default: ;
            endcase
        end
    endtask

    // One bus cycle: drive at negedge, queue the model prediction, compare after the edge.
    task automatic step(input logic [2:0] a, input logic w, input logic [31:0] d);
        exp_t e;
        @(negedge clk);
        bus.address   = a;
        bus.writedata = d;
        if (w) begin
            bus.chipselect = 1'b1;
            bus.write_n    = 1'b0;
        end else if ($urandom_range(0, 1) == 0) begin
            bus.chipselect = 1'b0;
            bus.write_n    = 1'($urandom_range(0, 1));
        end else begin
            bus.chipselect = 1'b1;
            bus.write_n    = 1'b1;
        end
        e.rd = model_read(a);
        model_update(w, a, d);
        e.out = {16'd0, m_out};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("out_port", {16'd0, out_port}, e.out);
        check("readdata", bus.readdata, e.rd);
        $display("t=%0t addr=%0d wr=%0d wd=0x%08h out=0x%04h rd=0x%08h", $time, a, w, d,
                 out_port, bus.readdata);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(3'd7, 1'b0, 32'd0);
    endtask

    // Assert reset mid-cycle with the bus quiet, check outputs immediately, release at negedge.
    task automatic async_reset();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_out", {16'd0, out_port}, 32'd0);
        check("rst_rd", bus.readdata, 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;
        model_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check("init_out", {16'd0, out_port}, 32'd0);
        check("init_rd", bus.readdata, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        step(3'd1, 1'b0, 32'd0);
        check("len_default", bus.readdata, 32'h0000_03E8);

        // Reset mid-cycle after a data write
        step(3'd0, 1'b1, 32'h0000_ABCD);
        async_reset();
        step(3'd1, 1'b0, 32'd0);
        check("len_after_rst", bus.readdata, 32'h0000_03E8);

        // DATA / OUTSET / OUTCLEAR
        step(3'd0, 1'b1, 32'h0000_1234);
        check("data_wr", {16'd0, out_port}, 32'h1234);
        step(3'd4, 1'b1, 32'h0000_00C0);
        check("outset", {16'd0, out_port}, 32'h12F4);
        step(3'd5, 1'b1, 32'h0000_0204);
        check("outclear", {16'd0, out_port}, 32'h10F0);
        step(3'd0, 1'b0, 32'd0);
        check("read_data", bus.readdata, 32'h0000_10F0);

        // Single pulse of 5 cycles
        step(3'd1, 1'b1, 32'd5);
        step(3'd0, 1'b1, 32'd0);
        step(3'd6, 1'b1, 32'h0000_0001);
        check("pulse5_start", {16'd0, out_port}, 32'h1);
        for (int i = 1; i <= 5; i++) begin
            step(3'd7, 1'b0, 32'd0);
            check("pulse5_busy", {31'd0, bus.readdata[0]}, 32'd1);
            check("pulse5_pin", {16'd0, out_port}, (i < 5) ? 32'h1 : 32'h0);
        end
        step(3'd7, 1'b0, 32'd0);
        check("pulse5_idle", {31'd0, bus.readdata[0]}, 32'd0);

        // Extending a running pulse with more bits
        step(3'd1, 1'b1, 32'd4);
        step(3'd6, 1'b1, 32'h0000_0003);
        idle(1);
        step(3'd6, 1'b1, 32'h0000_0004);
        check("ext_set", {16'd0, out_port}, 32'h7);
        idle(3);
        check("ext_hold", {16'd0, out_port}, 32'h7);
        idle(1);
        check("ext_clear", {16'd0, out_port}, 32'h0);

        // OUTSET/OUTCLEAR on masked bits
        step(3'd1, 1'b1, 32'd10);
        step(3'd0, 1'b1, 32'd0);
        step(3'd6, 1'b1, 32'h0000_00F0);
        idle(2);
        step(3'd4, 1'b1, 32'h0000_0010);
        step(3'd5, 1'b1, 32'h0000_0020);
        check("mask_edit", {16'd0, out_port}, 32'hD0);
        idle(5);
        check("mask_hold", {16'd0, out_port}, 32'hD0);
        idle(1);
        check("mask_expire", {16'd0, out_port}, 32'h10);

        // PULSE write landing on the expiry edge
        step(3'd1, 1'b1, 32'd3);
        step(3'd0, 1'b1, 32'd0);
        step(3'd6, 1'b1, 32'h0000_0001);
        idle(2);
        step(3'd6, 1'b1, 32'h0000_0002);
        check("exp_edge", {16'd0, out_port}, 32'h2);
        idle(3);
        check("exp_edge_end", {16'd0, out_port}, 32'h0);

        // Zero length pulse is ignored; reset during a pulse
        step(3'd0, 1'b1, 32'h0000_005A);
        step(3'd1, 1'b1, 32'd0);
        step(3'd6, 1'b1, 32'h0000_FFFF);
        check("len0_pin", {16'd0, out_port}, 32'h5A);
        step(3'd7, 1'b0, 32'd0);
        check("len0_status", bus.readdata, 32'd0);
        step(3'd1, 1'b1, 32'd8);
        step(3'd6, 1'b1, 32'h0000_0100);
        check("pulse8_pin", {16'd0, out_port}, 32'h15A);
        idle(2);
        async_reset();
        step(3'd7, 1'b0, 32'd0);
        check("rst_busy", bus.readdata, 32'd0);
        check("rst_pin", {16'd0, out_port}, 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            logic [2:0]  a;
            logic [31:0] d;
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            if (a == 3'd1) d = 32'($urandom_range(0, 12));
            if (a == 3'd0 && $urandom_range(0, 3) != 0) a = 3'd6;
            step(a, 1'($urandom_range(0, 1)), d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
